blink_rtc: RTL

//  Parametrised real-time clock and timer-interrupt controller for the Z88 gate array.

---
 rtl/blink_rtc_if.sv | 18 +
 rtl/blink_rtc.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/blink_rtc_if.sv
// blink_rtc_if: Z80 I/O bus port of the blink RTC (strobes, address, write data, registered read data).
interface blink_rtc_if;
  logic       io_wr;
  logic       io_rd;
  logic [7:0] io_addr;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;

  modport master (
    output io_wr, io_rd, io_addr, io_wdata,
    input  io_rdata
  );

  modport slave (
    input  io_wr, io_rd, io_addr, io_wdata,
    output io_rdata
  );
endinterface

// File: rtl/blink_rtc.sv
// blink_rtc: Z88 blink real-time clock - tick prescaler, tick/second/minute counters, timer interrupt.
// Option BLINK_RTC_SNAPSHOT_EN: a $D0 read latches tim1/timm into a shadow read back at $D1-$D4.
module blink_rtc #(
  parameter int TICK_DIV      = 49152,
  parameter int TICKS_PER_SEC = 200,
  parameter int SECS_PER_MIN  = 60,
  parameter int MIN_W         = 21
) (
  input  logic       mck,
  input  logic       rin,
  input  logic       restim,
  input  logic       inta,
  blink_rtc_if.slave bus,
  output logic       irq,
  output logic       tick_stb
);
  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0] presc;
  logic [7:0]       tim0;
  logic [5:0]       tim1;
  logic [MIN_W-1:0] timm;
  logic [2:0]       tsta;
  logic [2:0]       tsta_nxt;
  logic [2:0]       tmk;
  logic             gint;
  logic             tint;
  logic             tick;
  logic             sec_carry;
  logic             min_carry;
  logic             wr_b1;
  logic             wr_b4;
  logic             wr_b5;
  logic [5:0]       rd_tim1;
  logic [23:0]      rd_timm;
  logic             unused_wdata;

  assign tick      = !restim && (presc == PRE_W'(TICK_DIV - 1));
  assign sec_carry = tick && (tim0 == 8'(TICKS_PER_SEC - 1));
  assign min_carry = sec_carry && (tim1 == 6'(SECS_PER_MIN - 1));

  assign wr_b1 = bus.io_wr && (bus.io_addr == 8'hB1);
  assign wr_b4 = bus.io_wr && (bus.io_addr == 8'hB4);
  assign wr_b5 = bus.io_wr && (bus.io_addr == 8'hB5);

  assign unused_wdata = ^bus.io_wdata[7:3];

  // Prescaler and time counters
  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      presc    <= '0;
      tim0     <= '0;
      tim1     <= '0;
      timm     <= '0;
      tick_stb <= 1'b0;
    end else if (restim) begin
      presc    <= '0;
      tim0     <= '0;
      tim1     <= '0;
      timm     <= '0;
      tick_stb <= 1'b0;
    end else begin
      tick_stb <= tick;
      presc    <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        tim0 <= sec_carry ? '0 : tim0 + 8'd1;
        if (sec_carry)
          tim1 <= min_carry ? '0 : tim1 + 6'd1;
        if (min_carry)
          timm <= timm + 1'b1;
      end
    end
  end

  // Clears are applied first so an event on the same cycle always leaves its bit set
  always_comb begin
    tsta_nxt = tsta;
    if (wr_b4)
      tsta_nxt = tsta_nxt & ~bus.io_wdata[2:0];
    if (inta)
      tsta_nxt = tsta_nxt & ~tmk;
    tsta_nxt = tsta_nxt | {min_carry, sec_carry, tick};
    if (restim)
      tsta_nxt = '0;
  end

  // Status, mask, enables and registered interrupt request
  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      tsta <= '0;
      tmk  <= '0;
      gint <= 1'b0;
      tint <= 1'b0;
      irq  <= 1'b0;
    end else begin
      tsta <= tsta_nxt;
      if (wr_b1) begin
        gint <= bus.io_wdata[0];
        tint <= bus.io_wdata[1];
      end
      if (wr_b5)
        tmk <= bus.io_wdata[2:0];
      irq <= gint & tint & (|(tsta & tmk));
    end
  end

`ifdef BLINK_RTC_SNAPSHOT_EN
  logic [5:0]       snap_tim1;
  logic [MIN_W-1:0] snap_timm;

  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      snap_tim1 <= '0;
      snap_timm <= '0;
    end else if (bus.io_rd && (bus.io_addr == 8'hD0)) begin
      snap_tim1 <= tim1;
      snap_timm <= timm;
    end
  end

  assign rd_tim1 = snap_tim1;
  assign rd_timm = 24'(snap_timm);
`else
  assign rd_tim1 = tim1;
  assign rd_timm = 24'(timm);
`endif

  // Registered read data; undecoded reads keep the previous value
  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      bus.io_rdata <= '0;
    end else if (bus.io_rd) begin
      case (bus.io_addr)
        8'hB1:   bus.io_rdata <= {6'b0, irq, 1'b0};
        8'hB5:   bus.io_rdata <= {5'b0, tsta};
        8'hD0:   bus.io_rdata <= tim0;
        8'hD1:   bus.io_rdata <= {2'b0, rd_tim1};
        8'hD2:   bus.io_rdata <= rd_timm[7:0];
        8'hD3:   bus.io_rdata <= rd_timm[15:8];
        8'hD4:   bus.io_rdata <= rd_timm[23:16];
        default: bus.io_rdata <= bus.io_rdata;
      endcase
    end
  end
endmodule
